// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and small op-decoding helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational conditional two's-complement negation, one independent lane
// per operand so one instance can condition both operands or both results.
module muldiv_sign_fix #(
  parameter int W     = 32,
  parameter int LANES = 1
) (
  input  logic [LANES-1:0][W-1:0] val,
  input  logic [LANES-1:0]        neg,
  output logic [LANES-1:0][W-1:0] res
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign res[gi] = neg[gi] ? (~val[gi] + W'(1)) : val[gi];
    end
  endgenerate

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit: sign-magnitude pre-conditioning, WIDTH
// shift-add or restoring-division steps, then a sign-fix cycle into HI/LO.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int  WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 div_op_reg;
  logic                 b_zero_reg;
  logic                 neg_lo_reg;
  logic                 neg_hi_reg;
  logic [WIDTH-1:0]     a_orig_reg;
  logic [WIDTH-1:0]     opnd_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [WIDTH-1:0]     rem_reg;
  logic [WIDTH-1:0]     hi_reg, lo_reg;
  logic                 done_reg, div_zero_reg;

  logic [1:0][WIDTH-1:0]   fix_val, fix_res;
  logic [1:0]              fix_neg;
  logic [0:0][2*WIDTH-1:0] prod_val, prod_res;
  logic [0:0]              prod_neg;

  logic                 op_signed, op_div;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [WIDTH-1:0]     div_quo;

  assign op_signed = is_signed(op);
  assign op_div    = is_div(op);

  // One WIDTH-wide negator is shared: operands while idle, quotient/remainder in FIX.
  always_comb begin
    fix_val = '0;
    fix_neg = '0;
    if (state_reg == FIX) begin
      fix_val[0] = acc_reg[WIDTH-1:0];
      fix_val[1] = rem_reg;
      fix_neg[0] = neg_lo_reg;
      fix_neg[1] = neg_hi_reg;
    end else begin
      fix_val[0] = A;
      fix_val[1] = B;
      fix_neg[0] = op_signed & A[WIDTH-1];
      fix_neg[1] = op_signed & B[WIDTH-1];
    end
  end

  assign prod_val[0] = acc_reg;
  assign prod_neg[0] = neg_lo_reg;

  muldiv_sign_fix #(.W(WIDTH), .LANES(2)) u_fix_w (
    .val (fix_val),
    .neg (fix_neg),
    .res (fix_res)
  );

  muldiv_sign_fix #(.W(2*WIDTH), .LANES(1)) u_fix_2w (
    .val (prod_val),
    .neg (prod_neg),
    .res (prod_res)
  );

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // Divide: dividend bits leave acc MSB-first while quotient bits enter at the LSB.
  assign div_shift = {rem_reg, acc_reg[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_reg});
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_reg) : div_shift[WIDTH-1:0];
  assign div_quo   = {acc_reg[WIDTH-2:0], div_ge};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt_reg == LAST_CNT) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg != IDLE);
    done     = done_reg;
    hi       = hi_reg;
    lo       = lo_reg;
    div_zero = div_zero_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg      <= '0;
      div_op_reg   <= 1'b0;
      b_zero_reg   <= 1'b0;
      neg_lo_reg   <= 1'b0;
      neg_hi_reg   <= 1'b0;
      a_orig_reg   <= '0;
      opnd_reg     <= '0;
      acc_reg      <= '0;
      rem_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            cnt_reg    <= '0;
            div_op_reg <= op_div;
            b_zero_reg <= (B == '0);
            neg_lo_reg <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_hi_reg <= op_signed & A[WIDTH-1];
            a_orig_reg <= A;
            opnd_reg   <= op_div ? fix_res[1] : fix_res[0];
            acc_reg    <= {{WIDTH{1'b0}}, (op_div ? fix_res[0] : fix_res[1])};
            rem_reg    <= '0;
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (div_op_reg) begin
            acc_reg <= {acc_reg[2*WIDTH-1:WIDTH], div_quo};
            rem_reg <= div_rem;
          end else begin
            acc_reg <= mul_next;
          end
        end
        FIX: begin
          done_reg <= 1'b1;
          if (div_op_reg && b_zero_reg) begin
            hi_reg       <= a_orig_reg;
            lo_reg       <= '1;
            div_zero_reg <= 1'b1;
          end else if (div_op_reg) begin
            hi_reg       <= fix_res[1];
            lo_reg       <= fix_res[0];
            div_zero_reg <= 1'b0;
          end else begin
            hi_reg       <= prod_res[0][2*WIDTH-1:WIDTH];
            lo_reg       <= prod_res[0][WIDTH-1:0];
            div_zero_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: a reference model pushes expected HI/LO,
// div_zero and completion cycle at issue; the monitor pops on each done.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;   // edges from the negedge that drives start to done sample

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    longint       due;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  int     busy_run = 0;
  logic   prev_done = 1'b0;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sbv, p;
    logic [63:0] up;
    e.op = o; e.a = a; e.b = b; e.dz = 1'b0; e.due = 0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      OP_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        e.hi = up[63:32]; e.lo = up[31:0];
      end
      OP_MULT: begin
        p = sa * sbv; up = p;
        e.hi = up[63:32]; e.lo = up[31:0];
      end
      default: begin
        if (b == '0) begin
          e.hi = a; e.lo = '1; e.dz = 1'b1;
        end else if (o == OP_DIVU) begin
          e.lo = a / b; e.hi = a % b;
        end else begin
          p = sa / sbv; up = p; e.lo = up[31:0];
          p = sa % sbv; up = p; e.hi = up[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Waits (bounded) for an idle negedge, then presents one start cycle.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("issue_idle", {63'b0, busy}, 64'd0);
    e = model(o, a, b);
    e.due = cyc + LAT;
    sb.push_back(e);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: one sample per cycle, 1 time unit after the active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (busy) begin
      busy_run++;
    end else begin
      if (done) check("busy_len", 64'(busy_run), 64'(W + 1));
      busy_run = 0;
    end
    if (done) begin
      check("done_width", {63'b0, prev_done}, 64'd0);
      check("sb_has_entry", {63'b0, sb.size() == 0}, 64'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("txn op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b (exp hi=%h lo=%h dz=%0b)",
                 e.op, e.a, e.b, hi, lo, div_zero, e.hi, e.lo, e.dz);
        check("hi", {32'b0, hi}, {32'b0, e.hi});
        check("lo", {32'b0, lo}, {32'b0, e.lo});
        check("div_zero", {63'b0, div_zero}, {63'b0, e.dz});
        check("latency", 64'(cyc), 64'(e.due));
      end
    end
    prev_done = done;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    check("rst_div_zero", {63'b0, div_zero}, 64'd0);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(OP_MULT,  32'hFFFFFFFD, 32'd5);
    issue(OP_MULT,  32'h80000000, 32'h80000000);
    issue(OP_DIV,   32'hFFFFFFF9, 32'd2);
    issue(OP_DIVU,  32'd100,      32'd7);
    issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF);
    issue(OP_DIVU,  32'd7,        32'd0);
    issue(OP_MULTU, 32'd2,        32'd3);
    issue(OP_DIV,   32'hFFFFFF00, 32'd0);
    drain();

    // Junk start and operand churn while busy must not disturb the running op.
    issue(OP_DIVU, 32'd1000, 32'd33);
    repeat (5) @(negedge clk);
    start = 1'b1; op = OP_MULT; A = 32'h12345678; B = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0; A = 32'hDEADBEEF; B = 32'h0;
    drain();

    for (int i = 0; i < 8; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom, (i == 3) ? 32'd1 : $urandom);
    end
    issue(OP_DIV, 32'h7FFFFFFF, 32'hFFFFFFFE);
    issue(OP_DIVU, 32'd100, 32'd7);
    drain();

    // Reset at iteration 10 of a DIV: immediate abort, no done pulse.
    issue(OP_DIV, 32'hFFFF0000, 32'd3);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(OP_MULTU, 32'd2, 32'd3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
